// File: rtl/apb_reg_bridge_pkg.sv
// apb_reg_bridge_pkg: shared FSM encoding and constants for the APB to reg_native bridge.
package apb_reg_bridge_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK, DONE} bridge_state_e;

    localparam logic TIMEOUT_RDATA = '0;

endpackage

// File: rtl/apb_reg_native_bridge_if.sv
// apb_reg_native_bridge_if: APB3 slave bus plus reg_native request/ack bus around the bridge.
// slave is the bridge's view; master is the APB master together with the register slave.
interface apb_reg_native_bridge_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 32
);

    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pready;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pslverr;
    logic                  req_vld;
    logic                  wr_en;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  ack_vld;
    logic [DATA_WIDTH-1:0] rd_data;

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, ack_vld, rd_data,
        output pready, prdata, pslverr, req_vld, wr_en, rd_en, addr, wr_data
    );

    modport master (
        output psel, penable, pwrite, paddr, pwdata, ack_vld, rd_data,
        input  pready, prdata, pslverr, req_vld, wr_en, rd_en, addr, wr_data
    );

endinterface

// File: rtl/apb_reg_tmo_cnt.sv
// apb_reg_tmo_cnt: read-ack timeout counter; expired flags the last allowed WAIT_ACK cycle.
module apb_reg_tmo_cnt #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TMO_CNT_W      = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TMO_CNT_W-1:0] cnt;

    assign expired = en && cnt == TMO_CNT_W'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en && cnt != TMO_CNT_W'(TIMEOUT_CYCLES)) cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/apb_reg_native_bridge.sv
// apb_reg_native_bridge: APB3 slave to reg_native master; posted writes, reads wait for ack with timeout.
// Define APB_REG_ERR_RESP_EN to raise pslverr on read timeout and to reject misaligned addresses.
module apb_reg_native_bridge
    import apb_reg_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic                    clk,
    input logic                    rstn,
    apb_reg_native_bridge_if.slave bus
);

    localparam int TMO_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    bridge_state_e state, nxt;
    logic          wr_q;
    logic          err_q;
    logic          setup;
    logic          capture;
    logic          bad;
    logic          expired;

    assign setup   = bus.psel && !bus.penable;
    assign capture = state == IDLE && setup;

    apb_reg_tmo_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TMO_CNT_W     (TMO_CNT_W)
    ) u_tmo (
        .clk    (clk),
        .rstn   (rstn),
        .clr    (state == DONE),
        .en     (state == WAIT_ACK),
        .expired(expired)
    );

`ifdef APB_REG_ERR_RESP_EN
    localparam int                    ADDR_LSB   = $clog2(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((64'd1 << ADDR_LSB) - 64'd1);
    logic tmo_q;
    assign bad         = |(bus.paddr & ALIGN_MASK);
    assign bus.pslverr = bus.pready && (err_q || tmo_q);
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) tmo_q <= 1'b0;
        else if (state == DONE) tmo_q <= 1'b0;
        else if (state == WAIT_ACK && !bus.ack_vld && expired) tmo_q <= 1'b1;
    end
`else
    assign bad         = 1'b0;
    assign bus.pslverr = 1'b0;
`endif

    // an ack arriving in REQ skips WAIT_ACK; ack beats a same-cycle timeout
    always_comb begin
        nxt = state;
        case (state)
            IDLE:     nxt = setup ? REQ : IDLE;
            REQ:      nxt = (wr_q || err_q || bus.ack_vld) ? DONE : WAIT_ACK;
            WAIT_ACK: nxt = (bus.ack_vld || expired) ? DONE : WAIT_ACK;
            default:  nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            wr_q        <= 1'b0;
            err_q       <= 1'b0;
            bus.req_vld <= 1'b0;
            bus.wr_en   <= 1'b0;
            bus.rd_en   <= 1'b0;
            bus.pready  <= 1'b0;
            bus.addr    <= '0;
            bus.wr_data <= '0;
            bus.prdata  <= '0;
        end else begin
            state       <= nxt;
            bus.req_vld <= capture && !bad;
            bus.wr_en   <= capture && !bad && bus.pwrite;
            bus.rd_en   <= capture && !bad && !bus.pwrite;
            bus.pready  <= nxt == DONE;
            if (capture) begin
                bus.addr    <= bus.paddr;
                bus.wr_data <= bus.pwdata;
                wr_q        <= bus.pwrite;
                err_q       <= bad;
            end
            if (state == REQ && (wr_q || err_q)) bus.prdata <= '0;
            else if ((state == REQ || state == WAIT_ACK) && bus.ack_vld) bus.prdata <= bus.rd_data;
            else if (state == WAIT_ACK && expired) bus.prdata <= {DATA_WIDTH{TIMEOUT_RDATA}};
        end
    end

endmodule

// File: tb/tb_apb_reg_native_bridge.sv
// tb_apb_reg_native_bridge: directed APB transfers against a cycle-schedule model of the bridge.
module tb_apb_reg_native_bridge;

    localparam int T = 4;
    localparam int N = 1024;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    bit          exp_req  [N];
    bit          exp_wr   [N];
    bit          exp_rdy  [N];
    bit          exp_err  [N];
    logic [63:0] exp_addr [N];
    logic [31:0] exp_wd   [N];
    logic [31:0] exp_pd   [N];
    logic [31:0] held = '0;

    apb_reg_native_bridge_if #(.ADDR_WIDTH(64), .DATA_WIDTH(32)) bus ();

    apb_reg_native_bridge #(
        .ADDR_WIDTH    (64),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected timeline of one transfer whose setup cycle is s; k = ack delay after req_vld, -1 for none.
    task automatic plan(input bit wr, input logic [63:0] a, input logic [31:0] d, input int k,
                        input logic [31:0] rd, input int s);
        bit mis;
        int done;
`ifdef APB_REG_ERR_RESP_EN
        mis = a[1:0] != 2'b00;
`else
        mis = 1'b0;
`endif
        if (!mis) begin
            exp_req[s+1]  = 1'b1;
            exp_wr[s+1]   = wr;
            exp_addr[s+1] = a;
            exp_wd[s+1]   = d;
        end
        if (wr || mis) begin
            done          = s + 2;
            exp_pd[done]  = '0;
            exp_err[done] = mis;
        end else if (k >= 0 && k <= T) begin
            done          = s + 2 + k;
            exp_pd[done]  = rd;
            exp_err[done] = 1'b0;
        end else begin
            done          = s + 2 + T;
            exp_pd[done]  = '0;
`ifdef APB_REG_ERR_RESP_EN
            exp_err[done] = 1'b1;
`else
            exp_err[done] = 1'b0;
`endif
        end
        exp_rdy[done] = 1'b1;
    endtask

    task automatic forget_future();
        for (int i = cyc; i < N; i++) begin
            exp_req[i] = 1'b0;
            exp_rdy[i] = 1'b0;
        end
    endtask

    task automatic xfer(input bit wr, input logic [63:0] a, input logic [31:0] d, input int k,
                        input logic [31:0] rd, output int lat, output logic [31:0] pd, output logic err);
        int s = cyc;
        int n = 0;
        plan(wr, a, d, k, rd, s);
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = wr;
        bus.paddr   = a;
        bus.pwdata  = d;
        tick();
        bus.penable = 1'b1;
        while (!bus.pready && n < 40) begin
            bus.ack_vld = k >= 0 && cyc == s + 1 + k;
            bus.rd_data = bus.ack_vld ? rd : 32'hDEADBEEF;
            tick();
            n++;
        end
        checks++;
        if (!bus.pready) begin
            errors++;
            $display("FAIL xfer_pready_wait: actual no pready required pready within 40 cycles (addr %0h)", a);
        end
        lat         = cyc - s;
        pd          = bus.prdata;
        err         = bus.pslverr;
        bus.ack_vld = 1'b0;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rstn) begin
            held = '0;
            chk("reset_outputs", 64'({bus.pready, bus.pslverr, bus.req_vld, bus.wr_en, bus.rd_en,
                                      |bus.prdata, |bus.addr, |bus.wr_data}), 64'd0);
        end else begin
            if (exp_rdy[cyc]) held = exp_pd[cyc];
            chk("pready", 64'(bus.pready), 64'(exp_rdy[cyc]));
            chk("req_vld", 64'(bus.req_vld), 64'(exp_req[cyc]));
            chk("prdata", 64'(bus.prdata), 64'(held));
            chk("pslverr", 64'(bus.pslverr), 64'(exp_rdy[cyc] && exp_err[cyc]));
            if (exp_req[cyc]) begin
                chk("wr_en", 64'(bus.wr_en), 64'(exp_wr[cyc]));
                chk("rd_en", 64'(bus.rd_en), 64'(!exp_wr[cyc]));
                chk("addr", bus.addr, exp_addr[cyc]);
                chk("wr_data", 64'(bus.wr_data), 64'(exp_wd[cyc]));
            end
        end
    end

    initial begin
        int          lat;
        int          s;
        logic [31:0] pd;
        logic        err;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = '0;
        bus.pwdata  = '0;
        bus.ack_vld = 1'b0;
        bus.rd_data = '0;
        tick(3);
        rstn = 1'b1;
        tick();
        xfer(1'b1, 64'h10, 32'hCAFEF00D, -1, 32'h0, lat, pd, err);
        chk("wr_latency", 64'(lat), 64'd2);
        chk("wr_pslverr", 64'(err), 64'd0);
        tick();
        xfer(1'b0, 64'h20, 32'h0, 3, 32'h12345678, lat, pd, err);
        chk("rd_k3_latency", 64'(lat), 64'd5);
        chk("rd_k3_data", 64'(pd), 64'h12345678);
        tick();
        xfer(1'b0, 64'h24, 32'h0, 0, 32'hA5A50F0F, lat, pd, err);
        chk("rd_k0_latency", 64'(lat), 64'd2);
        chk("rd_k0_data", 64'(pd), 64'hA5A50F0F);
        tick();
        xfer(1'b1, 64'h28, 32'h11112222, -1, 32'h0, lat, pd, err);
        chk("wr_prdata_zero", 64'(pd), 64'd0);
        tick();
        xfer(1'b0, 64'h2C, 32'h0, -1, 32'h0, lat, pd, err);
        chk("tmo_latency", 64'(lat), 64'd6);
        chk("tmo_data", 64'(pd), 64'd0);
`ifdef APB_REG_ERR_RESP_EN
        chk("tmo_pslverr", 64'(err), 64'd1);
`else
        chk("tmo_pslverr", 64'(err), 64'd0);
`endif
        bus.ack_vld = 1'b1;
        bus.rd_data = 32'h5555AAAA;
        tick(3);
        bus.ack_vld = 1'b0;
        tick();
        xfer(1'b0, 64'h30, 32'h0, T, 32'h0BEEF000, lat, pd, err);
        chk("ack_beats_tmo_latency", 64'(lat), 64'd6);
        chk("ack_beats_tmo_data", 64'(pd), 64'h0BEEF000);
        tick();
        s = cyc;
        plan(1'b0, 64'h34, 32'h0, -1, 32'h0, s);
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = 64'h34;
        tick();
        bus.penable = 1'b1;
        tick();
        rstn = 1'b0;
        forget_future();
        tick();
        rstn        = 1'b1;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.ack_vld = 1'b1;
        bus.rd_data = 32'h00000077;
        tick(2);
        bus.ack_vld = 1'b0;
        tick();
        xfer(1'b1, 64'h40, 32'h0BADF00D, -1, 32'h0, lat, pd, err);
        chk("post_reset_wr_latency", 64'(lat), 64'd2);
        tick();
        xfer(1'b0, 64'h22, 32'h0, 1, 32'h0F0F0F0F, lat, pd, err);
`ifdef APB_REG_ERR_RESP_EN
        chk("misaligned_latency", 64'(lat), 64'd2);
        chk("misaligned_data", 64'(pd), 64'd0);
        chk("misaligned_pslverr", 64'(err), 64'd1);
`else
        chk("misaligned_latency", 64'(lat), 64'd3);
        chk("misaligned_data", 64'(pd), 64'h0F0F0F0F);
`endif
        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
